// File: rtl/zone_climate_ctrl_pkg.sv
// zone_climate_ctrl_pkg: shared state encoding and counter sizing for the climate controller.
package zone_climate_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAT = 2'd1,
        COOL = 2'd2,
        REST = 2'd3
    } zone_state_e;

    function automatic int cnt_width(input int min_on, input int rest_cyc);
        int m;
        m = (min_on > rest_cyc) ? min_on : rest_cyc;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/zone_climate_ctrl_zone_fsm.sv
// zone_fsm: one zone's heat/cool state machine with minimum-on time and rest interval.
module zone_fsm
    import zone_climate_ctrl_pkg::*;
#(
    parameter int MIN_ON   = 4,
    parameter int REST_CYC = 3,
    parameter int CW       = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic heat_on_i,
    input  logic heat_done_i,
    input  logic cool_on_i,
    input  logic cool_done_i,
    output logic heat_o,
    output logic cool_o
);

    localparam logic [CW-1:0] ON_LD   = CW'((MIN_ON > 0) ? MIN_ON - 1 : 0);
    localparam logic [CW-1:0] REST_LD = CW'((REST_CYC > 0) ? REST_CYC - 1 : 0);
    localparam zone_state_e   EXIT_ST = (REST_CYC > 0) ? REST : IDLE;

    zone_state_e   state_q;
    logic [CW-1:0] cnt_q;
    logic          heat_q, cool_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            heat_q  <= 1'b0;
            cool_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en_i && heat_on_i) begin
                        state_q <= HEAT;
                        cnt_q   <= ON_LD;
                        heat_q  <= 1'b1;
                    end else if (en_i && cool_on_i) begin
                        state_q <= COOL;
                        cnt_q   <= ON_LD;
                        cool_q  <= 1'b1;
                    end
                end
                HEAT: begin
                    if (!en_i || (cnt_q == '0 && heat_done_i)) begin
                        state_q <= EXIT_ST;
                        cnt_q   <= REST_LD;
                        heat_q  <= 1'b0;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                COOL: begin
                    if (!en_i || (cnt_q == '0 && cool_done_i)) begin
                        state_q <= EXIT_ST;
                        cnt_q   <= REST_LD;
                        cool_q  <= 1'b0;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
                    else state_q <= IDLE;
                end
            endcase
        end
    end

    assign heat_o = heat_q;
    assign cool_o = cool_q;

endmodule

// File: rtl/zone_climate_ctrl.sv
// zone_climate_ctrl: multi-zone hysteretic heat/cool controller with shared runtime thresholds.
module zone_climate_ctrl
    import zone_climate_ctrl_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int ZONES    = 2,
    parameter int HYST     = 2,
    parameter int MIN_ON   = 4,
    parameter int REST_CYC = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ZONES*WIDTH-1:0]   temp_i,
    input  logic [ZONES-1:0]         enable_i,
    input  logic [WIDTH-1:0]         heat_th_i,
    input  logic [WIDTH-1:0]         cool_th_i,
    output logic [ZONES-1:0]         heat_o,
    output logic [ZONES-1:0]         cool_o,
    output logic                     cfg_err_o
);

    localparam int TW = WIDTH + 2;
    localparam int CW = cnt_width(MIN_ON, REST_CYC);

    logic [TW-1:0] heat_th, cool_th, heat_off, cool_off;
    logic          cfg_ok;
    logic          cfg_err_q;

    // Two extra bits keep Heat_th+HYST and the validity sum from wrapping.
    assign heat_th  = TW'(heat_th_i);
    assign cool_th  = TW'(cool_th_i);
    assign heat_off = heat_th + TW'(HYST);
    assign cool_off = (cool_th >= TW'(HYST)) ? cool_th - TW'(HYST) : '0;
    assign cfg_ok   = cool_th >= heat_th + TW'(2 * HYST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cfg_err_q <= 1'b0;
        else cfg_err_q <= !cfg_ok;
    end

    assign cfg_err_o = cfg_err_q;

    for (genvar i = 0; i < ZONES; i++) begin : g_zone
        logic [TW-1:0] t;
        assign t = TW'(temp_i[i*WIDTH +: WIDTH]);
        zone_fsm #(
            .MIN_ON  (MIN_ON),
            .REST_CYC(REST_CYC),
            .CW      (CW)
        ) u_fsm (
            .clk        (clk),
            .rst_n      (rst_n),
            .en_i       (enable_i[i] & cfg_ok),
            .heat_on_i  (t < heat_th),
            .heat_done_i(t >= heat_off),
            .cool_on_i  (t > cool_th),
            .cool_done_i(t <= cool_off),
            .heat_o     (heat_o[i]),
            .cool_o     (cool_o[i])
        );
    end

endmodule

// File: tb/tb_zone_climate_ctrl.sv
// tb_zone_climate_ctrl: directed plus randomized checks against a cycle-level behavioural model.
module tb_zone_climate_ctrl;

    localparam int WIDTH    = 8;
    localparam int ZONES    = 2;
    localparam int HYST     = 2;
    localparam int MIN_ON   = 4;
    localparam int REST_CYC = 3;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [ZONES*WIDTH-1:0] temp;
    logic [ZONES-1:0]       enable;
    logic [WIDTH-1:0]       heat_th, cool_th;
    logic [ZONES-1:0]       heat_o, cool_o;
    logic                   cfg_err_o;

    int n_vec = 0;
    int n_err = 0;

    // Model: mode 0 off, 1 heating, 2 cooling, 3 resting.
    int mode[ZONES];
    int on_cycles[ZONES];
    int rest_left[ZONES];
    bit exp_cfg_err;

    always #5 clk = ~clk;

    zone_climate_ctrl #(
        .WIDTH(WIDTH), .ZONES(ZONES), .HYST(HYST), .MIN_ON(MIN_ON), .REST_CYC(REST_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .temp_i   (temp),
        .enable_i (enable),
        .heat_th_i(heat_th),
        .cool_th_i(cool_th),
        .heat_o   (heat_o),
        .cool_o   (cool_o),
        .cfg_err_o(cfg_err_o)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got=%b expected=%b", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int z = 0; z < ZONES; z++) begin
            mode[z] = 0;
            on_cycles[z] = 0;
            rest_left[z] = 0;
        end
        exp_cfg_err = 0;
    endtask

    task automatic leave(input int z);
        if (REST_CYC == 0) mode[z] = 0;
        else begin
            mode[z] = 3;
            rest_left[z] = REST_CYC;
        end
    endtask

    task automatic model_edge();
        int h, c, t, coff;
        bit ok, en;
        h = int'(heat_th);
        c = int'(cool_th);
        ok = c >= h + 2 * HYST;
        coff = (c - HYST < 0) ? 0 : c - HYST;
        for (int z = 0; z < ZONES; z++) begin
            t = int'(temp[z*WIDTH +: WIDTH]);
            en = enable[z] && ok;
            case (mode[z])
                0: if (en && t < h) begin mode[z] = 1; on_cycles[z] = 1; end
                   else if (en && t > c) begin mode[z] = 2; on_cycles[z] = 1; end
                1: if (!en || (on_cycles[z] >= MIN_ON && t >= h + HYST)) leave(z);
                   else on_cycles[z]++;
                2: if (!en || (on_cycles[z] >= MIN_ON && t <= coff)) leave(z);
                   else on_cycles[z]++;
                default: begin
                    rest_left[z]--;
                    if (rest_left[z] == 0) mode[z] = 0;
                end
            endcase
        end
        exp_cfg_err = !ok;
    endtask

    task automatic compare(input string tag);
        logic [7:0] eh, ec;
        eh = '0;
        ec = '0;
        for (int z = 0; z < ZONES; z++) begin
            eh[z] = (mode[z] == 1);
            ec[z] = (mode[z] == 2);
        end
        chk({tag, ".heat"}, 8'(heat_o), eh);
        chk({tag, ".cool"}, 8'(cool_o), ec);
        chk({tag, ".cfg_err"}, 8'(cfg_err_o), 8'(exp_cfg_err));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare(tag);
    endtask

    task automatic steps(input int n, input string tag);
        for (int k = 0; k < n; k++) step(tag);
    endtask

    task automatic set_t(input int z, input int v);
        temp[z*WIDTH +: WIDTH] = WIDTH'(v);
    endtask

    // Reset asserted between edges must clear outputs without waiting for a clock.
    task automatic async_reset(input int cycles);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare("rst_async");
        for (int k = 0; k < cycles; k++) @(posedge clk);
        @(negedge clk);
        compare("rst_hold");
        rst_n = 1'b1;
    endtask

    initial begin
        int r;
        rst_n   = 1'b0;
        temp    = '0;
        set_t(0, 70);
        set_t(1, 70);
        enable  = 2'b11;
        heat_th = 8'd65;
        cool_th = 8'd85;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare("reset");
        rst_n = 1'b1;

        steps(3, "idle70");
        set_t(0, 93);
        steps(2, "cool_enter");
        set_t(0, 60);
        steps(12, "cool_to_heat");

        set_t(0, 70);
        steps(10, "settle");
        set_t(1, 64);
        steps(6, "hyst_on");
        set_t(1, 66);
        steps(2, "hyst_hold");
        set_t(1, 67);
        steps(5, "hyst_off");
        set_t(1, 70);
        steps(6, "settle");

        set_t(0, 93);
        steps(2, "en_cool");
        enable = 2'b10;
        step("en_drop");
        enable = 2'b11;
        steps(6, "en_rest");
        set_t(0, 70);
        steps(8, "settle");

        set_t(0, 60);
        steps(3, "cfg_heat");
        heat_th = 8'd80;
        cool_th = 8'd82;
        steps(2, "cfg_bad");
        heat_th = 8'd65;
        cool_th = 8'd85;
        steps(8, "cfg_restore");
        set_t(0, 70);
        steps(10, "settle");

        set_t(0, 60);
        set_t(1, 95);
        steps(12, "indep");

        set_t(1, 70);
        steps(2, "heat_before_rst");
        async_reset(2);
        steps(3, "post_rst");

        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 199);
            if (r == 0) async_reset(1);
            for (int z = 0; z < ZONES; z++) begin
                if ($urandom_range(0, 3) == 0) begin
                    r = $urandom_range(0, 39);
                    set_t(z, (r == 0) ? 0 : (r == 1) ? 255 : $urandom_range(55, 100));
                end
                enable[z] = ($urandom_range(0, 19) != 0);
            end
            r = $urandom_range(0, 59);
            case (r)
                0: begin heat_th = 8'd80; cool_th = 8'd82; end
                1: begin heat_th = 8'd65; cool_th = 8'd85; end
                2: begin heat_th = 8'd255; cool_th = 8'd255; end
                3: begin heat_th = 8'd0; cool_th = 8'd4; end
                4: begin heat_th = 8'd70; cool_th = 8'd74; end
                5: begin
                    heat_th = 8'($urandom_range(50, 80));
                    cool_th = heat_th + 8'($urandom_range(4, 20));
                end
                default: ;
            endcase
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/zone_climate_ctrl.md
Name: zone_climate_ctrl

Overview:
- Multi-zone successor to the single-zone temperature controller in the smart-home automation top level.
- Each zone has a hysteretic heat/cool FSM with a minimum-on time and a post-run rest (anti-short-cycle) interval.
- Heat and cool thresholds are shared runtime inputs instead of fixed constants.
- Outputs drive per-zone heater and cooler relays.

Parameters:
- WIDTH, 8: temperature and threshold width, unsigned.
- ZONES, 2: number of independent zones.
- HYST, 2: hysteresis band, in temperature units.
- MIN_ON, 4: minimum cycles a zone stays in HEAT or COOL once entered.
- REST_CYC, 3: cycles a zone is held off after leaving HEAT or COOL.

Ports:
- CLK  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low. Reset=0 clears all state immediately.
- Temp  input  ZONES*WIDTH  per-zone temperature; zone i is Temp[i*WIDTH +: WIDTH].
- Enable  input  ZONES  per-zone enable.
- Heat_th  input  WIDTH  heat-on threshold.
- Cool_th  input  WIDTH  cool-on threshold.
- Heat  output  ZONES  heater relay per zone.
- Cool  output  ZONES  cooler relay per zone.
- Cfg_err  output  1  threshold configuration invalid.

Behaviour:
- Reset (Reset=0, async):
  - Heat=0, Cool=0, Cfg_err=0.
  - All zones go to IDLE; counters cleared.
  - Reset mid-HEAT/COOL drops the relays immediately, with no rest interval.
- All outputs are registered. Inputs sampled at edge k appear on outputs after edge k (1-cycle latency).
- Threshold arithmetic is done in WIDTH+2 bits; no wrap-around.
  - heat_off = Heat_th+HYST.
  - cool_off = Cool_th-HYST, saturating at 0.
- Configuration check:
  - Valid iff Cool_th >= Heat_th + 2*HYST (compared in WIDTH+2 bits).
  - If invalid at edge k: Cfg_err=1 after edge k, and every zone is treated as Enable=0.
  - Cfg_err=0 after the first edge where the configuration is valid.
- Per-zone FSM, states IDLE, HEAT, COOL, REST; cnt = per-zone down-counter.
  - IDLE:
    - en & Temp<Heat_th -> HEAT, cnt=MIN_ON-1.
    - else en & Temp>Cool_th -> COOL, cnt=MIN_ON-1.
    - else stay. Heat takes priority (cannot conflict when config is valid).
  - HEAT, Heat=1:
    - !en -> REST, cnt=REST_CYC-1, regardless of cnt.
    - else cnt!=0 -> decrement.
    - else Temp>=heat_off -> REST, cnt=REST_CYC-1.
    - else stay.
  - COOL, Cool=1: mirror of HEAT, with exit condition Temp<=cool_off.
  - REST, outputs 0: cnt!=0 -> decrement; cnt==0 -> IDLE.
  - REST cannot be shortened by Enable or temperature.
  - If REST_CYC=0, exits go directly to IDLE.
- Heat and Cool are never both 1 for the same zone.
- A HEAT->COOL or COOL->HEAT transition always passes through at least REST_CYC cycles of REST plus one IDLE cycle.
- Zones are fully independent; the only shared inputs are the thresholds and the Cfg_err gating.
- Counter width: $clog2(max(MIN_ON,REST_CYC)+1), minimum 1.

Decomposition:
- Shared package / header `climate_defs`:
  - state encoding constants (IDLE=2'd0, HEAT=2'd1, COOL=2'd2, REST=2'd3);
  - counter-width function.
- Sub-module `zone_fsm`:
  - one zone's FSM, counter and relay registers;
  - takes precomputed heat_on/heat_off/cool_on/cool_off compare bits and the gated enable.
- Top:
  - threshold arithmetic, config check, Cfg_err register;
  - generate loop over ZONES.

Test Plan:
Defaults for all scenarios: WIDTH=8, ZONES=2, HYST=2, MIN_ON=4, REST_CYC=3, Heat_th=65, Cool_th=85, Enable=2'b11.
- Reset: Reset=0 for 2 cycles, then 1 -> Heat=Cool=00, Cfg_err=0. Reassert Reset=0 while zone0 is heating -> Heat[0]=0 with no clock edge.
- Zone0 sequence 70 -> 93 -> 60 (others steady at 70):
  - 70 -> no outputs.
  - 93 -> Cool[0]=1 one edge later.
  - 60 applied after 1 cycle of cooling -> Cool[0] held until 4 cycles total, then 3 cycles of all-off (REST), 1 IDLE cycle, then Heat[0]=1.
- Hysteresis: zone1 at 64 -> Heat[1]=1.
  - Hold past MIN_ON, then 66 -> stays on.
  - 67 -> Heat[1]=0 after the next edge; REST for 3 cycles.
- Enable drop: Enable[0]=0 during COOL with cnt=2 -> Cool[0]=0 after the next edge; REST 3 cycles even if Enable returns to 1.
- Config error: Heat_th=80, Cool_th=82 while zone0 is heating -> Cfg_err=1 and Heat[0]=0 after one edge. Restore 65/85 -> Cfg_err=0 one edge later; zone re-enters HEAT only after REST.
- Independence: zone0=60, zone1=95 simultaneously -> Heat=01, Cool=10 on the same edge; both zones obey their own MIN_ON and REST timing.
